// File: rtl/aemb2_idiv.sv
// ---------------------------------------------------------------------------
// aemb2_idiv -- iterative 32-bit integer divider (idiv / idivu)
//
// Radix-2 restoring divider, one quotient bit per qualifying clock
// (rising gclk edge with dena=1). Signed operations divide magnitudes and
// fix the quotient sign afterwards. A zero divisor finishes immediately
// with a zero quotient and the divide-by-zero flag set.
//
// Parameters
//   AEMB_DIV   1 = divider present, 0 = all outputs tied low
//
// Ports
//   gclk       in   1  clock, rising edge
//   grst       in   1  asynchronous active-high reset
//   dena       in   1  pipeline enable; state only advances when high
//   div_start  in   1  start request, sampled in IDLE only
//   div_sgn    in   1  1 = signed, 0 = unsigned
//   opa_of     in  32  divisor
//   opb_of     in  32  dividend
//   div_mx     out 32  quotient (0 from accepted start until result)
//   div_busy   out  1  high in CALC and FIX
//   div_done   out  1  high for the single DONE cycle
//   div_dbz    out  1  divide-by-zero flag, held until next start
// ---------------------------------------------------------------------------
module aemb2_idiv #(
  parameter int AEMB_DIV = 1
) (
  input  logic        gclk,
  input  logic        grst,
  input  logic        dena,
  input  logic        div_start,
  input  logic        div_sgn,
  input  logic [31:0] opa_of,
  input  logic [31:0] opb_of,
  output logic [31:0] div_mx,
  output logic        div_busy,
  output logic        div_done,
  output logic        div_dbz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  generate
    if (AEMB_DIV != 0) begin : g_div

      state_t      r_state;
      logic [4:0]  r_cnt;
      logic [31:0] r_rem;   // restored remainder, always < divisor
      logic [31:0] r_quo;   // dividend shifting out, quotient shifting in
      logic [31:0] r_dvs;   // divisor magnitude
      logic        r_neg;   // signed op with opposite operand signs
      logic [31:0] r_mx;
      logic        r_dbz;

      logic [31:0] w_abs_a;
      logic [31:0] w_abs_b;
      logic [32:0] w_shf;
      logic [32:0] w_try;
      logic        w_lt;

      // Two's complement magnitude; 0x80000000 wraps onto itself, which is
      // what makes the signed overflow case come out as 0x80000000.
      assign w_abs_a = (div_sgn && opa_of[31]) ? (32'd0 - opa_of) : opa_of;
      assign w_abs_b = (div_sgn && opb_of[31]) ? (32'd0 - opb_of) : opb_of;

      // 33-bit partial remainder: {rem, dividend} << 1. Because the stored
      // remainder is below the divisor, a non-negative trial result always
      // fits in 32 bits, so only 32 bits need to be kept between steps.
      assign w_shf = {r_rem, r_quo[31]};
      assign w_try = w_shf - {1'b0, r_dvs};
      assign w_lt  = w_try[32];

      always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_rem   <= '0;
          r_quo   <= '0;
          r_dvs   <= '0;
          r_neg   <= 1'b0;
          r_mx    <= '0;
          r_dbz   <= 1'b0;
        end else if (dena) begin
          unique case (r_state)
            IDLE: begin
              if (div_start) begin
                r_dvs <= w_abs_a;
                r_quo <= w_abs_b;
                r_rem <= '0;
                r_neg <= div_sgn & (opa_of[31] ^ opb_of[31]);
                r_cnt <= '0;
                r_mx  <= '0;
                if (opa_of == '0) begin
                  r_dbz   <= 1'b1;
                  r_state <= DONE;
                end else begin
                  r_dbz   <= 1'b0;
                  r_state <= CALC;
                end
              end
            end
            CALC: begin
              r_rem <= w_lt ? w_shf[31:0] : w_try[31:0];
              r_quo <= {r_quo[30:0], ~w_lt};
              r_cnt <= r_cnt + 5'd1;
              if (r_cnt == 5'd31) begin
                r_state <= FIX;
              end
            end
            FIX: begin
              r_mx    <= r_neg ? (32'd0 - r_quo) : r_quo;
              r_state <= DONE;
            end
            DONE: begin
              r_state <= IDLE;
            end
            default: begin
              r_state <= IDLE;
            end
          endcase
        end
      end

      assign div_mx   = r_mx;
      assign div_busy = (r_state == CALC) || (r_state == FIX);
      assign div_done = (r_state == DONE);
      assign div_dbz  = r_dbz;

    end else begin : g_nodiv

      logic w_unused_ins;
      assign w_unused_ins = ^{gclk, grst, dena, div_start, div_sgn,
                              opa_of, opb_of};

      assign div_mx   = '0;
      assign div_busy = 1'b0;
      assign div_done = 1'b0;
      assign div_dbz  = 1'b0;

    end
  endgenerate

endmodule

// File: tb/tb_aemb2_idiv.sv
// ---------------------------------------------------------------------------
// tb_aemb2_idiv -- scoreboard bench for aemb2_idiv
//
// The stimulus process pushes the expected quotient, dbz flag, completion
// cycle and busy-cycle count for each division; a monitor on the falling
// clock edge pops an entry whenever div_done is high and compares.
// ---------------------------------------------------------------------------
module tb_aemb2_idiv;

  logic        gclk = 1'b0;
  logic        grst = 1'b0;
  logic        dena = 1'b1;
  logic        div_start = 1'b0;
  logic        div_sgn = 1'b0;
  logic [31:0] opa_of = '0;
  logic [31:0] opb_of = '0;
  logic [31:0] div_mx;
  logic        div_busy;
  logic        div_done;
  logic        div_dbz;

  aemb2_idiv #(.AEMB_DIV(1)) dut (
    .gclk      (gclk),
    .grst      (grst),
    .dena      (dena),
    .div_start (div_start),
    .div_sgn   (div_sgn),
    .opa_of    (opa_of),
    .opb_of    (opb_of),
    .div_mx    (div_mx),
    .div_busy  (div_busy),
    .div_done  (div_done),
    .div_dbz   (div_dbz)
  );

  always #5 gclk = ~gclk;

  typedef struct {
    string       name;
    logic [31:0] q;
    logic        dbz;
    int unsigned done_cyc;
    int unsigned busy;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned busy_cnt = 0;
  int unsigned total = 0;
  int unsigned bad = 0;

  always @(posedge gclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge gclk) begin
    exp_t e;
    if (grst) begin
      busy_cnt = 0;
    end else begin
      if (div_busy) busy_cnt++;
      if (div_done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check({e.name, ".q"},    div_mx,          e.q);
          check({e.name, ".dbz"},  {31'd0, div_dbz}, {31'd0, e.dbz});
          check({e.name, ".cyc"},  cyc,             e.done_cyc);
          check({e.name, ".busy"}, busy_cnt,        e.busy);
        end
        busy_cnt = 0;
      end
    end
  end

  // Called at posedge+1; the next posedge is the start edge.
  task automatic do_div(input string name, input logic sgn,
                        input logic [31:0] dividend, input logic [31:0] divisor,
                        input logic [31:0] exp_q, input logic exp_dbz,
                        input int unsigned stall, input bit poke);
    exp_t e;
    bit   fin;
    e.name     = name;
    e.q        = exp_q;
    e.dbz      = exp_dbz;
    e.done_cyc = cyc + (exp_dbz ? 1 : 34 + stall);
    e.busy     = exp_dbz ? 0 : 33 + stall;
    sb.push_back(e);
    div_sgn   = sgn;
    opb_of    = dividend;
    opa_of    = divisor;
    div_start = 1'b1;
    @(posedge gclk); #1;
    div_start = 1'b0;
    check({name, ".mx_cleared"}, div_mx, 32'd0);
    check({name, ".start_dbz"}, {31'd0, div_dbz}, {31'd0, exp_dbz});
    check({name, ".start_busy"}, {31'd0, div_busy}, {31'd0, ~exp_dbz});
    if (poke) begin
      repeat (4) begin @(posedge gclk); #1; end
      div_start = 1'b1;
      div_sgn   = 1'b1;
      opa_of    = 32'd3;
      opb_of    = 32'd999;
      @(posedge gclk); #1;
      div_start = 1'b0;
    end
    if (stall > 0) begin
      dena = 1'b0;
      repeat (stall) begin @(posedge gclk); #1; end
      dena = 1'b1;
    end
    fin = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge gclk); #1;
      if (sb.size() == 0) begin
        fin = 1'b1;
        break;
      end
    end
    if (!fin) begin
      check({name, ".timeout"}, 32'd0, 32'd1);
      sb.delete();
    end
    repeat (2) begin @(posedge gclk); #1; end
    check({name, ".hold_mx"},   div_mx, exp_q);
    check({name, ".hold_dbz"},  {31'd0, div_dbz}, {31'd0, exp_dbz});
    check({name, ".hold_done"}, {31'd0, div_done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 grst = 1'b1;
    #1;
    check("rst.mx",   div_mx, 32'd0);
    check("rst.busy", {31'd0, div_busy}, 32'd0);
    check("rst.done", {31'd0, div_done}, 32'd0);
    check("rst.dbz",  {31'd0, div_dbz}, 32'd0);
    repeat (2) @(posedge gclk);
    #1 grst = 1'b0;

    do_div("u100_7",     1'b0, 32'd100,       32'd7,         32'd14,        1'b0, 0, 1'b0);
    do_div("s-100_7",    1'b1, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  1'b0, 0, 1'b0);
    do_div("s_ovf",      1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1'b0, 0, 1'b0);
    do_div("dbz",        1'b0, 32'd5,         32'd0,         32'd0,         1'b1, 0, 1'b0);
    do_div("u_max_1",    1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  1'b0, 0, 1'b0);
    do_div("u_max_16",   1'b0, 32'hFFFFFFFF,  32'd16,        32'h0FFFFFFF,  1'b0, 0, 1'b0);
    do_div("u_small",    1'b0, 32'd5,         32'd10,        32'd0,         1'b0, 0, 1'b0);
    do_div("s100_-7",    1'b1, 32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  1'b0, 0, 1'b0);
    do_div("s-100_-7",   1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        1'b0, 0, 1'b0);
    do_div("u_8000_ffff",1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         1'b0, 0, 1'b0);
    do_div("s-7_2",      1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  1'b0, 0, 1'b0);
    do_div("u_hex",      1'b0, 32'h12345678,  32'h00001234,  32'h00010004,  1'b0, 0, 1'b0);
    do_div("s_dbz",      1'b1, 32'hFFFFFF9C,  32'd0,         32'd0,         1'b1, 0, 1'b0);
    do_div("stall",      1'b0, 32'd1000,      32'd3,         32'd333,       1'b0, 5, 1'b1);

    // Abort a division with an asynchronous reset after 10 iterations.
    div_sgn   = 1'b0;
    opb_of    = 32'd1000;
    opa_of    = 32'd3;
    div_start = 1'b1;
    @(posedge gclk); #1;
    div_start = 1'b0;
    repeat (10) @(posedge gclk);
    #1;
    check("abort.pre_busy", {31'd0, div_busy}, 32'd1);
    #2 grst = 1'b1;
    #1;
    check("abort.mx",   div_mx, 32'd0);
    check("abort.busy", {31'd0, div_busy}, 32'd0);
    check("abort.done", {31'd0, div_done}, 32'd0);
    check("abort.dbz",  {31'd0, div_dbz}, 32'd0);
    repeat (2) @(posedge gclk);
    #1 grst = 1'b0;

    do_div("u20_4", 1'b0, 32'd20, 32'd4, 32'd5, 1'b0, 0, 1'b0);

    repeat (3) @(posedge gclk);
    #1;
    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
